// File: rtl/lab5_led_fader_if.sv
// Pattern/control inputs and LED/busy outputs of the LED fader.
// The master drives pattern and mode controls; the fader is the slave.
interface lab5_led_fader_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] pattern_in;
    logic             enable;
    logic             fade_en;
    logic [WIDTH-1:0] led_out;
    logic             busy;

    modport master (
        output pattern_in,
        output enable,
        output fade_en,
        input  led_out,
        input  busy
    );

    modport slave (
        input  pattern_in,
        input  enable,
        input  fade_en,
        output led_out,
        output busy
    );
endinterface

// File: rtl/lab5_led_fader.sv
// PWM LED fader: ramps each LED brightness toward its on/off target and
// drives the pins with a registered PWM waveform.
module lab5_led_fader #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned PWM_BITS     = 4,
    parameter int unsigned PWM_PRESCALE = 16,
    parameter int unsigned RAMP_DIV     = 50000
) (
    input  logic             clk,
    input  logic             reset,
    lab5_led_fader_if.slave  bus
);

    localparam int unsigned PRE_W  = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
    localparam int unsigned RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    localparam logic [PWM_BITS-1:0] MAX       = '1;
    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PWM_PRESCALE - 1);
    localparam logic [RAMP_W-1:0]   RAMP_LAST = RAMP_W'(RAMP_DIV - 1);

    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [RAMP_W-1:0]   ramp_cnt;
    logic                pwm_tick_c;
    logic                ramp_tick_c;

    logic [PWM_BITS-1:0] level       [WIDTH];
    logic [PWM_BITS-1:0] level_nxt_c [WIDTH];
    logic [PWM_BITS-1:0] target_c    [WIDTH];

    logic [WIDTH-1:0]    led_nxt_c;
    logic [WIDTH-1:0]    diff_c;
    logic [WIDTH-1:0]    led_q;
    logic                busy_q;

    assign pwm_tick_c  = (pre_cnt == PRE_LAST);
    assign ramp_tick_c = (ramp_cnt == RAMP_LAST);

    // Free-running PWM prescaler, PWM counter and ramp timer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt  <= '0;
            pwm_cnt  <= '0;
            ramp_cnt <= '0;
        end else begin
            pre_cnt  <= pwm_tick_c ? '0 : pre_cnt + PRE_W'(1);
            ramp_cnt <= ramp_tick_c ? '0 : ramp_cnt + RAMP_W'(1);
            if (pwm_tick_c) begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            target_c[i] = bus.pattern_in[i] ? MAX : '0;
        end
    end

    // Next level: snap in instant mode, single saturating step per ramp tick otherwise
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            level_nxt_c[i] = level[i];
            if (!bus.fade_en) begin
                level_nxt_c[i] = target_c[i];
            end else if (ramp_tick_c) begin
                if (level[i] < target_c[i]) begin
                    level_nxt_c[i] = level[i] + PWM_BITS'(1);
                end else if (level[i] > target_c[i]) begin
                    level_nxt_c[i] = level[i] - PWM_BITS'(1);
                end
            end
        end
    end

    // MAX has no off slot so a fully-on LED never flickers
    always_comb begin
        led_nxt_c = '0;
        diff_c    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            led_nxt_c[i] = bus.enable & ((level[i] == MAX) | (level[i] > pwm_cnt));
            diff_c[i]    = (level[i] != target_c[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                level[i] <= '0;
            end
            led_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                level[i] <= level_nxt_c[i];
            end
            led_q  <= led_nxt_c;
            busy_q <= |diff_c;
        end
    end

    assign bus.led_out = led_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_lab5_led_fader.sv
// Self-checking bench for lab5_led_fader: directed scenarios plus random
// stimulus compared against a cycle-count based behavioural model.
module tb_lab5_led_fader;

    localparam int unsigned W    = 16;
    localparam int unsigned MAXL = 15;
    localparam int unsigned STEPS = 16;
    localparam int unsigned RDIV = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    lab5_led_fader_if #(.WIDTH(W)) bus ();

    lab5_led_fader #(
        .WIDTH       (W),
        .PWM_BITS    (4),
        .PWM_PRESCALE(1),
        .RAMP_DIV    (RDIV)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: everything derives from the number of clock edges
    // since reset release. With a prescale of 1 the PWM phase is that count
    // mod 16, and a brightness step happens on every 4th edge.
    int         m_cyc;
    int         m_level [W];
    logic [W-1:0] m_led;
    logic       m_busy;

    function automatic int tgt_of(input logic b);
        return b ? int'(MAXL) : 0;
    endfunction

    function automatic int step_toward(input int lvl, input int tgt);
        if (lvl < tgt) return lvl + 1;
        if (lvl > tgt) return lvl - 1;
        return lvl;
    endfunction

    function automatic logic model_any_diff(input logic [W-1:0] p);
        logic d;
        d = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            if (m_level[i] != tgt_of(p[i])) d = 1'b1;
        end
        return d;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cyc  <= 0;
            m_led  <= '0;
            m_busy <= 1'b0;
            for (int i = 0; i < int'(W); i++) m_level[i] <= 0;
        end else begin
            m_cyc  <= m_cyc + 1;
            m_busy <= model_any_diff(bus.pattern_in);
            for (int i = 0; i < int'(W); i++) begin
                if (!bus.fade_en)
                    m_level[i] <= tgt_of(bus.pattern_in[i]);
                else if ((m_cyc % int'(RDIV)) == int'(RDIV) - 1)
                    m_level[i] <= step_toward(m_level[i], tgt_of(bus.pattern_in[i]));
                m_led[i] <= bus.enable &&
                            (m_level[i] == int'(MAXL) || m_level[i] > (m_cyc % int'(STEPS)));
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bit seen_busy;
        bus.pattern_in = 16'hFFFF;
        bus.fade_en    = 1'b1;
        bus.enable     = 1'b1;
        reset          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.led_out !== 16'h0000) $display("FAIL reset_led actual=%h expected=0000", bus.led_out);
        else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy actual=%b expected=0", bus.busy);
        else n_pass++;
        reset = 1'b0;
        seen_busy = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (bus.busy === 1'b1) seen_busy = 1'b1;
        end
        n_checks++;
        if (!seen_busy) $display("FAIL reset_busy_rise actual=0 expected=1 within 2 clks");
        else n_pass++;
    endtask

    task automatic test_fade_in();
        int errs;
        apply_reset();
        bus.pattern_in = 16'h0001;
        bus.fade_en    = 1'b1;
        bus.enable     = 1'b1;
        errs = 0;
        repeat (64) begin
            @(posedge clk); #1;
            if (bus.led_out !== m_led || bus.busy !== m_busy) begin
                errs++;
                if (errs < 4)
                    $display("FAIL fade_in_cycle led=%h/%h busy=%b/%b (actual/expected)",
                             bus.led_out, m_led, bus.busy, m_busy);
            end
        end
        n_checks++;
        if (errs != 0) $display("FAIL fade_in_model mismatches=%0d expected=0", errs);
        else n_pass++;
        n_checks++;
        if (dut.level[0] !== 4'd15) $display("FAIL fade_in_level actual=%0d expected=15", dut.level[0]);
        else n_pass++;
        errs = 0;
        repeat (16) begin
            @(posedge clk); #1;
            if (bus.led_out !== 16'h0001 || bus.busy !== 1'b0) errs++;
        end
        n_checks++;
        if (errs != 0) $display("FAIL fade_in_full_on bad_cycles=%0d expected=0", errs);
        else n_pass++;
    endtask

    task automatic test_instant();
        int busy_cnt;
        int errs;
        @(posedge clk); #1;
        bus.fade_en    = 1'b0;
        bus.pattern_in = 16'hA5A5;
        busy_cnt = 0;
        @(posedge clk); #1;
        if (bus.busy === 1'b1) busy_cnt++;
        @(posedge clk); #1;
        if (bus.busy === 1'b1) busy_cnt++;
        n_checks++;
        if (bus.led_out !== 16'hA5A5) $display("FAIL instant_2nd_clk actual=%h expected=a5a5", bus.led_out);
        else n_pass++;
        errs = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.led_out !== 16'hA5A5) errs++;
        end
        n_checks++;
        if (errs != 0) $display("FAIL instant_steady bad_cycles=%0d expected=0", errs);
        else n_pass++;
        n_checks++;
        if (busy_cnt > 2 || busy_cnt < 1) $display("FAIL instant_busy_len actual=%0d expected=1..2", busy_cnt);
        else n_pass++;
    endtask

    task automatic test_reversal();
        int guard;
        int errs;
        int peak;
        apply_reset();
        bus.pattern_in = 16'h0001;
        bus.fade_en    = 1'b1;
        bus.enable     = 1'b1;
        guard = 0;
        while (m_level[0] != 6 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++;
        if (guard >= 200) $display("FAIL reversal_reach6 timeout level=%0d expected=6", m_level[0]);
        else n_pass++;
        bus.pattern_in = 16'h0000;
        errs = 0;
        peak = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (int'(dut.level[0]) > peak) peak = int'(dut.level[0]);
            if (bus.led_out !== m_led || bus.busy !== m_busy) errs++;
        end
        n_checks++;
        if (peak > 6) $display("FAIL reversal_no_step_up actual_peak=%0d expected<=6", peak);
        else n_pass++;
        n_checks++;
        if (errs != 0) $display("FAIL reversal_model mismatches=%0d expected=0", errs);
        else n_pass++;
        n_checks++;
        if (dut.level[0] !== 4'd0 || bus.busy !== 1'b0)
            $display("FAIL reversal_end level=%0d busy=%b expected level=0 busy=0", dut.level[0], bus.busy);
        else n_pass++;
    endtask

    task automatic test_enable();
        int guard;
        int errs;
        apply_reset();
        bus.pattern_in = 16'h00FF;
        bus.fade_en    = 1'b1;
        bus.enable     = 1'b1;
        guard = 0;
        while (m_level[0] != 10 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++;
        if (guard >= 200) $display("FAIL enable_reach10 timeout level=%0d expected=10", m_level[0]);
        else n_pass++;
        bus.enable = 1'b0;
        errs = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.led_out !== 16'h0000) errs++;
        end
        n_checks++;
        if (errs != 0) $display("FAIL enable_dark bad_cycles=%0d expected=0", errs);
        else n_pass++;
        n_checks++;
        if (dut.level[0] !== 4'd15) $display("FAIL enable_level_tracks actual=%0d expected=15", dut.level[0]);
        else n_pass++;
        bus.enable = 1'b1;
        errs = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.led_out !== m_led || bus.busy !== m_busy) errs++;
        end
        n_checks++;
        if (errs != 0) $display("FAIL enable_resume mismatches=%0d expected=0", errs);
        else n_pass++;
    endtask

    task automatic test_reset_mid_ramp();
        int guard;
        int errs;
        apply_reset();
        bus.pattern_in = 16'hFFFF;
        bus.fade_en    = 1'b1;
        bus.enable     = 1'b1;
        guard = 0;
        while (m_level[0] != 9 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.led_out !== 16'h0000 || dut.level[0] !== 4'd0 || bus.busy !== 1'b0)
            $display("FAIL reset_mid_ramp led=%h level=%0d busy=%b expected 0000/0/0",
                     bus.led_out, dut.level[0], bus.busy);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        errs = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (bus.led_out !== m_led || bus.busy !== m_busy) errs++;
        end
        n_checks++;
        if (errs != 0) $display("FAIL reset_restart mismatches=%0d expected=0", errs);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs;
        apply_reset();
        errs = 0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 19) == 0) bus.pattern_in = W'($urandom);
            if ($urandom_range(0, 39) == 0) bus.enable     = ~bus.enable;
            if ($urandom_range(0, 59) == 0) bus.fade_en    = ~bus.fade_en;
            @(posedge clk); #1;
            if (bus.led_out !== m_led || bus.busy !== m_busy) begin
                errs++;
                if (errs < 4)
                    $display("FAIL random_cycle c=%0d led=%h/%h busy=%b/%b (actual/expected)",
                             c, bus.led_out, m_led, bus.busy, m_busy);
            end
        end
        n_checks++;
        if (errs != 0) $display("FAIL random_model mismatches=%0d expected=0", errs);
        else n_pass++;
    endtask

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        reset          = 1'b0;
        bus.pattern_in = '0;
        bus.enable     = 1'b1;
        bus.fade_en    = 1'b1;
        #1;
        test_reset();
        test_fade_in();
        test_instant();
        test_reversal();
        test_enable();
        test_reset_mid_ramp();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
